// File: rtl/ctrlpid_pkg.sv
// Shared types and constants for the ctrlpid PWM stage: FSM states,
// drive-direction encoding and the PWM period helper.
package ctrlpid_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Full-scale magnitude of a signed w-bit word; also the PWM period in clocks.
  function automatic int pmax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/ctrlpid_deadtime.sv
// Loadable down-counter timing the bridge dead band. busy while the count
// is nonzero; expire flags the last dead cycle.
module ctrlpid_deadtime #(
  parameter int dtw = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [dtw-1:0] value,
  output logic           busy,
  output logic           expire
);

  logic [dtw-1:0] count_q;
  logic [dtw-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy   = (count_q != '0);
  assign expire = (count_q == dtw'(1));

endmodule

// File: rtl/ctrlpid_pwm.sv
// Sign-magnitude H-bridge PWM with dead time on reversal.
// Optional brake on zero duty: define CTRLPID_PWM_BRAKE_EN.
module ctrlpid_pwm
  import ctrlpid_pkg::*;
#(
  parameter int ow  = 12,
  parameter int dtw = 6
) (
  input  logic           clk_pid,
  input  logic           reset,
  input  logic [ow-1:0]  m_k,
  input  logic [dtw-1:0] dead_time,
  output logic           pwm_a,
  output logic           pwm_b,
  output logic           period_start,
  output logic           dir,
  output state_t         dbg_state
);

  localparam int CW   = ow - 1;
  localparam int PMAX = pmax(ow);
  localparam logic [CW-1:0] CNT_LAST = CW'(PMAX - 1);
  localparam logic [CW-1:0] MAG_MAX  = CW'(PMAX);

`ifdef CTRLPID_PWM_BRAKE_EN
  localparam bit BRAKE = 1'b1;
`else
  localparam bit BRAKE = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] mag_q, mag_d;
  logic          sign_q, sign_d;
  logic          dir_q, dir_d;
  logic          pwm_a_q, pwm_a_d;
  logic          pwm_b_q, pwm_b_d;
  logic          ps_q, ps_d;

  logic [ow-1:0] m_neg;
  logic [CW-1:0] mag_n;
  logic          sign_n;
  logic          boundary;
  logic          mode_chg;
  logic          dt_load, dt_busy, dt_expire;
  logic          drive, brake_on, duty_on;

  // Most negative input has no positive twin; it saturates to full scale.
  always_comb begin
    m_neg  = -m_k;
    sign_n = m_k[ow-1];
    if (!sign_n) begin
      mag_n = m_k[CW-1:0];
    end else if (m_neg[ow-1]) begin
      mag_n = MAG_MAX;
    end else begin
      mag_n = m_neg[CW-1:0];
    end
  end

  // A mode is brake (zero duty, brake build only) or a drive direction.
  always_comb begin
    mode_chg = ((BRAKE && (mag_q == '0)) != (BRAKE && (mag_n == '0)))
             || ((mag_n != '0) && (sign_n != dir_q));
  end

  always_comb begin
    boundary = (cnt_q == CNT_LAST);
    cnt_d    = boundary ? '0 : cnt_q + 1'b1;
    mag_d    = boundary ? mag_n : mag_q;
    sign_d   = boundary ? sign_n : sign_q;
    state_d  = state_q;
    dir_d    = dir_q;
    dt_load  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (boundary) begin
          if (mode_chg && (dead_time != '0)) begin
            state_d = ST_DEAD;
            dt_load = 1'b1;
          end else if (mag_n != '0) begin
            dir_d = sign_n;
          end
        end
      end
      ST_DEAD: begin
        if (dt_expire || !dt_busy) begin
          state_d = ST_RUN;
          if (mag_d != '0) begin
            dir_d = sign_d;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Compare against next-state count so outputs line up with cnt.
    drive    = (state_d == ST_RUN);
    brake_on = drive && BRAKE && (mag_d == '0);
    duty_on  = drive && (cnt_d < mag_d);
    pwm_a_d  = brake_on || (duty_on && (dir_d == DIR_FWD));
    pwm_b_d  = brake_on || (duty_on && (dir_d == DIR_REV));
    ps_d     = (cnt_d == '0);
  end

  always_ff @(posedge clk_pid) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      dir_q   <= DIR_FWD;
      pwm_a_q <= 1'b0;
      pwm_b_q <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      dir_q   <= dir_d;
      pwm_a_q <= pwm_a_d;
      pwm_b_q <= pwm_b_d;
      ps_q    <= ps_d;
    end
  end

  ctrlpid_deadtime #(
    .dtw(dtw)
  ) u_deadtime (
    .clk    (clk_pid),
    .reset  (reset),
    .load   (dt_load),
    .value  (dead_time),
    .busy   (dt_busy),
    .expire (dt_expire)
  );

  assign pwm_a        = pwm_a_q;
  assign pwm_b        = pwm_b_q;
  assign period_start = ps_q;
  assign dir          = dir_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ctrlpid_pwm.sv
// Bench for ctrlpid_pwm: per-period reference schedule checked every cycle,
// a table of whole-period duty counts, random periods and a mid-period reset.
module tb_ctrlpid_pwm;

  localparam int OW   = 12;
  localparam int DTW  = 6;
  localparam int PMAX = 2047;

`ifdef CTRLPID_PWM_BRAKE_EN
  localparam bit BRAKE = 1'b1;
`else
  localparam bit BRAKE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [OW-1:0]  m_k = '0;
  logic [DTW-1:0] dead_time = '0;
  logic           pwm_a, pwm_b, period_start, dir;
  ctrlpid_pkg::state_t dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference: position in period plus the plan for the current period.
  int pos      = 0;
  bit first    = 1'b1;
  int p_mag    = 0;
  bit old_dir  = 1'b0;
  bit new_dir  = 1'b0;
  int dead_len = 0;

  typedef struct {
    logic [OW-1:0] mk;
    int            dt;
    int            exp_a;
    int            exp_b;
    bit            exp_dir;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  ctrlpid_pwm #(
    .ow (OW),
    .dtw(DTW)
  ) dut (
    .clk_pid      (clk),
    .reset        (reset),
    .m_k          (m_k),
    .dead_time    (dead_time),
    .pwm_a        (pwm_a),
    .pwm_b        (pwm_b),
    .period_start (period_start),
    .dir          (dir),
    .dbg_state    (dbg_state)
  );

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int v, nm;
    bit ns, chg, cur_brk, new_brk;
    if (reset) begin
      pos = 0; first = 1'b1; p_mag = 0;
      old_dir = 1'b0; new_dir = 1'b0; dead_len = 0;
    end else begin
      if (!first && pos == PMAX - 1) begin
        v  = int'($signed(m_k));
        ns = (v < 0);
        nm = ns ? -v : v;
        if (nm > PMAX) nm = PMAX;
        cur_brk = BRAKE && (p_mag == 0);
        new_brk = BRAKE && (nm == 0);
        chg = (cur_brk != new_brk) || (nm != 0 && ns != new_dir);
        old_dir  = new_dir;
        if (nm != 0) new_dir = ns;
        dead_len = chg ? int'(dead_time) : 0;
        p_mag = nm;
        pos = 0;
      end else begin
        pos = pos + 1;
      end
      first = 1'b0;
    end
  endtask

  task automatic check_cycle();
    bit in_dead, d, drv, brk, ea, eb, eps;
    logic [4:0] exp_v, act_v;
    in_dead = !first && (pos < dead_len);
    d   = first ? 1'b0 : (in_dead ? old_dir : new_dir);
    drv = !first && !in_dead;
    brk = drv && BRAKE && (p_mag == 0);
    ea  = brk || (drv && p_mag != 0 && !d && pos < p_mag);
    eb  = brk || (drv && p_mag != 0 && d && pos < p_mag);
    eps = !first && (pos == 0);
    exp_v = {ea, eb, eps, d, in_dead};
    act_v = {pwm_a, pwm_b, period_start, dir, dbg_state == ctrlpid_pkg::ST_DEAD};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL cycle pos=%0d {a,b,ps,dir,dead}: got %b expected %b", pos, act_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_cycle();
  endtask

  task automatic to_boundary();
    for (int g = 0; g < PMAX + 2 && !(pos == PMAX - 1 && !first); g++) tick();
  endtask

  task automatic add(input logic [OW-1:0] mk, input int dt, input int a, input int b, input bit d);
    vec_t v;
    v = '{mk, dt, a, b, d};
    tbl.push_back(v);
  endtask

  task automatic run_entry(input int idx, input vec_t v);
    int ca, cb;
    to_boundary();
    m_k = v.mk;
    dead_time = DTW'(v.dt);
    ca = 0; cb = 0;
    repeat (PMAX) begin
      tick();
      ca += int'(pwm_a);
      cb += int'(pwm_b);
    end
    check_val($sformatf("vec%0d a_high", idx), ca, v.exp_a);
    check_val($sformatf("vec%0d b_high", idx), cb, v.exp_b);
    check_val($sformatf("vec%0d dir", idx), int'(dir), int'(v.exp_dir));
  endtask

  initial begin
    int n;
`ifdef CTRLPID_PWM_BRAKE_EN
    add(12'd0,   4, 2047, 2047, 1'b0);
    add(12'd300, 4, 296,  0,    1'b0);
    add(12'd0,   4, 2043, 2043, 1'b0);
    add(12'hF00, 0, 0,    256,  1'b1);
    add(12'h800, 7, 0,    2047, 1'b1);
`else
    add(12'd0,   10, 0,    0,    1'b0);
    add(12'd512, 10, 512,  0,    1'b0);
    add(12'hF00, 10, 0,    246,  1'b1);
    add(12'h800, 10, 0,    2047, 1'b1);
    add(12'h7FF, 0,  2047, 0,    1'b0);
    add(12'hFFF, 5,  0,    0,    1'b1);
    add(12'd0,   5,  0,    0,    1'b1);
    add(12'd100, 63, 37,   0,    1'b0);
    add(12'd100, 63, 100,  0,    1'b0);
    add(12'h801, 3,  0,    2044, 1'b1);
`endif

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_val("reset pwm_a", int'(pwm_a), 0);
    check_val("reset pwm_b", int'(pwm_b), 0);
    check_val("reset period_start", int'(period_start), 0);
    check_val("reset dir", int'(dir), 0);

    foreach (tbl[i]) run_entry(i, tbl[i]);

    // Random periods; dead_time is disturbed early in each period.
    for (int r = 0; r < 8; r++) begin
      to_boundary();
      case ($urandom_range(0, 4))
        0: m_k = OW'($urandom);
        1: m_k = '0;
        2: m_k = 12'h800;
        3: m_k = 12'h7FF;
        default: begin
          m_k = OW'($urandom_range(1, 40));
          if ($urandom_range(0, 1) == 1) m_k = -m_k;
        end
      endcase
      dead_time = DTW'($urandom_range(0, 63));
      repeat (3) tick();
      dead_time = DTW'($urandom_range(0, 63));
      repeat (PMAX - 3) tick();
    end

    // Reset in the middle of a high pwm_a stretch.
    to_boundary();
    m_k = 12'd512;
    dead_time = '0;
    repeat (101) tick();
    check_val("mid pwm_a high", int'(pwm_a), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("post-reset pwm_a", int'(pwm_a), 0);
    check_val("post-reset pwm_b", int'(pwm_b), 0);
    check_val("post-reset period_start", int'(period_start), 0);
    check_val("post-reset dir", int'(dir), 0);
    n = 0;
    for (int g = 0; g < PMAX + 5; g++) begin
      tick();
      n++;
      if (period_start) break;
    end
    check_val("first period_start delay", n, PMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
